mi_nios_cpu_ocimem_arbiter: RTL and testbench

Shares the single-port 256x32 on-chip debug memory (OCI RAM) between the JTAG debug path and the CPU's debug slave port. JTAG commands come in as sysclk-domain take_action/jdo strobes from the debug-module wrapper and are held in a one-deep pending slot. CPU accesses arrive as Avalon-MM read/write with waitrequest. Read data for JTAG is returned in MonDReg, with monitor_ready/monitor_error status.

---
 rtl/mi_nios_cpu_ocimem_pkg.sv | 23 ++
 rtl/mi_nios_cpu_ocimem_rr_arb.sv | 37 +++
 rtl/mi_nios_cpu_ocimem_arbiter.sv | 128 ++++++++++++
 tb/tb_mi_nios_cpu_ocimem_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mi_nios_cpu_ocimem_pkg.sv
// rtl/mi_nios_cpu_ocimem_pkg.sv - shared types and constants for the OCI RAM arbiter
// FSM states, JTAG op encoding, default widths and jdo field positions.
package mi_nios_cpu_ocimem_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;

  localparam int JDO_ADDR_LSB = 3;
  localparam int JDO_ADDR_MSB = 10;
  localparam int JDO_DATA_LSB = 3;
  localparam int JDO_DATA_MSB = 34;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_CPU_RD  = 2'd1;
  localparam state_t ST_JTAG_RD = 2'd2;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } jtag_op_t;

endpackage

// File: rtl/mi_nios_cpu_ocimem_rr_arb.sv
// rtl/mi_nios_cpu_ocimem_rr_arb.sv - 2-way JTAG/CPU grant logic for the OCI RAM
// OCIMEM_ARB_ROUND_ROBIN_EN selects round-robin; otherwise JTAG has fixed priority.
module mi_nios_cpu_ocimem_rr_arb (
`ifdef OCIMEM_ARB_ROUND_ROBIN_EN
  input  logic clk,
  input  logic reset,
`endif
  input  logic en,
  input  logic req_jtag,
  input  logic req_cpu,
  output logic gnt_jtag,
  output logic gnt_cpu
);

  logic jtag_wins;

`ifdef OCIMEM_ARB_ROUND_ROBIN_EN
  // Starts as "CPU granted last" so JTAG takes the first contention.
  logic last_cpu;

  assign jtag_wins = req_jtag && (!req_cpu || last_cpu);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_cpu <= 1'b1;
    end else if (gnt_jtag || gnt_cpu) begin
      last_cpu <= gnt_cpu;
    end
  end
`else
  assign jtag_wins = req_jtag;
`endif

  assign gnt_jtag = en && jtag_wins;
  assign gnt_cpu  = en && req_cpu && !jtag_wins;

endmodule

// File: rtl/mi_nios_cpu_ocimem_arbiter.sv
// rtl/mi_nios_cpu_ocimem_arbiter.sv - shares the OCI debug RAM between JTAG and the CPU slave port
// Contention policy chosen by OCIMEM_ARB_ROUND_ROBIN_EN (undefined: JTAG fixed priority).
module mi_nios_cpu_ocimem_arbiter
  import mi_nios_cpu_ocimem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [37:0]       jdo,
  input  logic              debugack,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [3:0]        ram_byteen,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  state_t            state;
  logic [ADDR_W-1:0] jaddr;
  logic              slot_valid;
  jtag_op_t          slot_op;
  logic [DATA_W-1:0] slot_data;

  logic arb_en, gnt_jtag, gnt_cpu;
  logic jtag_stb, stb_accept, jtag_wr_issue, jtag_rd_issue, cpu_rd_phase;

  // Reset gates the grant so nothing reaches the RAM while reset is held.
  assign arb_en = (state == ST_IDLE) && !reset;

  mi_nios_cpu_ocimem_rr_arb u_arb (
`ifdef OCIMEM_ARB_ROUND_ROBIN_EN
    .clk      (clk),
    .reset    (reset),
`endif
    .en       (arb_en),
    .req_jtag (slot_valid),
    .req_cpu  (avs_read || avs_write),
    .gnt_jtag (gnt_jtag),
    .gnt_cpu  (gnt_cpu)
  );

  assign jtag_wr_issue = gnt_jtag && (slot_op == OP_WR);
  assign jtag_rd_issue = gnt_jtag && (slot_op == OP_RD);
  assign cpu_rd_phase  = !reset && (state == ST_CPU_RD);

  // The slot frees on issue, so a strobe in the issue cycle still fits.
  assign jtag_stb   = take_action_ocimem_b || take_no_action_ocimem_a;
  assign stb_accept = jtag_stb && debugack && (!slot_valid || gnt_jtag);

  assign ram_addr        = gnt_cpu ? avs_address : jaddr;
  assign ram_wr          = (gnt_cpu && avs_write) || jtag_wr_issue;
  assign ram_byteen      = gnt_cpu ? avs_byteenable : 4'hF;
  assign ram_wdata       = gnt_cpu ? avs_writedata : slot_data;
  assign avs_readdata    = cpu_rd_phase ? ram_rdata : '0;
  assign avs_waitrequest = !(cpu_rd_phase || (gnt_cpu && avs_write));

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      jaddr         <= '0;
      slot_valid    <= 1'b0;
      slot_op       <= OP_RD;
      slot_data     <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (jtag_rd_issue) begin
            state <= ST_JTAG_RD;
          end else if (gnt_cpu && avs_read) begin
            state <= ST_CPU_RD;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (jtag_wr_issue) begin
        jaddr         <= jaddr + 1'b1;
        monitor_ready <= 1'b1;
      end
      if (state == ST_JTAG_RD) begin
        MonDReg       <= ram_rdata;
        monitor_ready <= 1'b1;
        jaddr         <= jaddr + 1'b1;
      end

      // A newly accepted command outranks a completion in the same cycle.
      if (stb_accept) begin
        slot_valid    <= 1'b1;
        slot_op       <= take_action_ocimem_b ? OP_WR : OP_RD;
        slot_data     <= jdo[JDO_DATA_MSB:JDO_DATA_LSB];
        monitor_ready <= 1'b0;
      end else if (gnt_jtag) begin
        slot_valid <= 1'b0;
      end

      if (take_action_ocimem_a) begin
        if (slot_valid) begin
          monitor_error <= 1'b1;
        end else begin
          jaddr         <= jdo[ADDR_W+JDO_ADDR_LSB-1:JDO_ADDR_LSB];
          monitor_error <= 1'b0;
        end
      end
      if (jtag_stb && !stb_accept) begin
        monitor_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mi_nios_cpu_ocimem_arbiter.sv
// tb/tb_mi_nios_cpu_ocimem_arbiter.sv - directed vector bench for the OCI RAM arbiter
// Contention expectations follow OCIMEM_ARB_ROUND_ROBIN_EN.
module tb_mi_nios_cpu_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
  logic [37:0] jdo;
  logic        debugack;
  logic [7:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic [7:0]  ram_addr;
  logic        ram_wr;
  logic [3:0]  ram_byteen;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mi_nios_cpu_ocimem_arbiter dut (
    .clk                     (clk),
    .reset                   (reset),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .jdo                     (jdo),
    .debugack                (debugack),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_byteenable          (avs_byteenable),
    .avs_readdata            (avs_readdata),
    .avs_waitrequest         (avs_waitrequest),
    .ram_addr                (ram_addr),
    .ram_wr                  (ram_wr),
    .ram_byteen              (ram_byteen),
    .ram_wdata               (ram_wdata),
    .ram_rdata               (ram_rdata),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  // Synchronous-read RAM model; preload seeds the word the CPU read expects.
  logic [31:0] mem [0:255];
  logic        preload;
  always @(posedge clk) begin
    if (preload) begin
      mem[8'h10] <= 32'h12345678;
    end else if (ram_wr) begin
      for (int b = 0; b < 4; b++)
        if (ram_byteen[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
    ram_rdata <= mem[ram_addr];
  end

  typedef struct packed {
    logic        ta_a, ta_b, tna_a, dbg, rd, wr;
    logic [7:0]  addr;
    logic [31:0] p;
    logic        e_wait;
    logic [31:0] e_rdata;
    logic        e_wr, chk_addr;
    logic [7:0]  e_addr;
    logic [31:0] e_wdata, e_mon;
    logic        e_rdy, e_err;
  } vec_t;

  vec_t vecs [0:21];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ta_a, input logic ta_b, input logic tna_a, input logic dbg,
                       input logic rd, input logic wr, input logic [7:0] addr,
                       input logic [31:0] wdata, input logic [31:0] p);
    take_action_ocimem_a    = ta_a;
    take_action_ocimem_b    = ta_b;
    take_no_action_ocimem_a = tna_a;
    debugack                = dbg;
    avs_read                = rd;
    avs_write               = wr;
    avs_address             = addr;
    avs_writedata           = wdata;
    avs_byteenable          = 4'hF;
    jdo                     = {3'b000, p, 3'b000};
  endtask

  localparam logic [31:0] DB = 32'hDEADBEEF;

  initial begin
    //          ta_a tb tna dbg rd wr addr   p              wait rdata         wr chk eaddr  ewdata         mon rdy err
    vecs[0]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,8'h00,32'h0,        1'b1,32'h0,        1'b0,1'b1,8'h00,32'h0,        32'h0,1'b0,1'b0};
    vecs[1]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,8'h00,32'hFF,       1'b1,32'h0,        1'b0,1'b1,8'h00,32'h0,        32'h0,1'b0,1'b0};
    vecs[2]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,8'h00,DB,           1'b1,32'h0,        1'b0,1'b1,8'hFF,32'h0,        32'h0,1'b0,1'b0};
    vecs[3]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,8'h00,32'h0,        1'b1,32'h0,        1'b1,1'b1,8'hFF,DB,           32'h0,1'b0,1'b0};
    vecs[4]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,8'h00,32'h0,        1'b1,32'h0,        1'b0,1'b1,8'h00,32'h0,        32'h0,1'b1,1'b0};
    vecs[5]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,8'h00,32'hFF,       1'b1,32'h0,        1'b0,1'b1,8'h00,32'h0,        32'h0,1'b1,1'b0};
    vecs[6]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,8'h00,32'h0,        1'b1,32'h0,        1'b0,1'b1,8'hFF,32'h0,        32'h0,1'b1,1'b0};
    vecs[7]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,8'h00,32'h0,        1'b1,32'h0,        1'b0,1'b1,8'hFF,32'h0,        32'h0,1'b0,1'b0};
    vecs[8]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,8'h00,32'h0,        1'b1,32'h0,        1'b0,1'b1,8'hFF,32'h0,        32'h0,1'b0,1'b0};
    vecs[9]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,8'h00,32'h0,        1'b1,32'h0,        1'b0,1'b1,8'h00,32'h0,        DB,   1'b1,1'b0};
    vecs[10] = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,8'h10,32'h0,        1'b1,32'h0,        1'b0,1'b1,8'h10,32'h0,        DB,   1'b1,1'b0};
    vecs[11] = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,8'h10,32'h0,        1'b0,32'h12345678, 1'b0,1'b0,8'h00,32'h0,        DB,   1'b1,1'b0};
    vecs[12] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,8'h00,32'h0,        1'b1,32'h0,        1'b0,1'b1,8'h00,32'h0,        DB,   1'b1,1'b0};
    vecs[13] = '{1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,8'h10,32'hA5A5A5A5, 1'b1,32'h0,        1'b0,1'b1,8'h10,32'h0,        DB,   1'b1,1'b0};
    vecs[14] = '{1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,8'h10,32'h22222222, 1'b0,32'h12345678, 1'b0,1'b0,8'h00,32'h0,        DB,   1'b0,1'b0};
    vecs[15] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,8'h00,32'h0,        1'b1,32'h0,        1'b1,1'b1,8'h00,32'hA5A5A5A5, DB,   1'b0,1'b1};
    vecs[16] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,8'h00,32'h0,        1'b1,32'h0,        1'b0,1'b1,8'h01,32'h0,        DB,   1'b1,1'b1};
    vecs[17] = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,8'h00,32'h05,       1'b1,32'h0,        1'b0,1'b1,8'h01,32'h0,        DB,   1'b1,1'b1};
    vecs[18] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,8'h00,32'h0,        1'b1,32'h0,        1'b0,1'b1,8'h05,32'h0,        DB,   1'b1,1'b0};
    vecs[19] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,8'h00,32'h0,        1'b1,32'h0,        1'b0,1'b1,8'h05,32'h0,        DB,   1'b1,1'b1};
    vecs[20] = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,8'h00,32'h07,       1'b1,32'h0,        1'b0,1'b1,8'h05,32'h0,        DB,   1'b1,1'b1};
    vecs[21] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,8'h00,32'h0,        1'b1,32'h0,        1'b0,1'b1,8'h07,32'h0,        DB,   1'b1,1'b0};

    reset   = 1'b1;
    preload = 1'b1;
    drive(0, 0, 0, 1, 0, 0, 8'h00, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    reset   = 1'b0;
    preload = 1'b0;

    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].ta_a, vecs[i].ta_b, vecs[i].tna_a, vecs[i].dbg,
            vecs[i].rd, vecs[i].wr, vecs[i].addr, 32'h0, vecs[i].p);
      #1;
      chk($sformatf("row%0d waitrequest", i), 32'(avs_waitrequest), 32'(vecs[i].e_wait));
      chk($sformatf("row%0d readdata", i), avs_readdata, vecs[i].e_rdata);
      chk($sformatf("row%0d ram_wr", i), 32'(ram_wr), 32'(vecs[i].e_wr));
      if (vecs[i].chk_addr) chk($sformatf("row%0d ram_addr", i), 32'(ram_addr), 32'(vecs[i].e_addr));
      if (vecs[i].e_wr) chk($sformatf("row%0d ram_wdata", i), ram_wdata, vecs[i].e_wdata);
      chk($sformatf("row%0d MonDReg", i), MonDReg, vecs[i].e_mon);
      chk($sformatf("row%0d monitor_ready", i), 32'(monitor_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("row%0d monitor_error", i), 32'(monitor_error), 32'(vecs[i].e_err));
      @(negedge clk);
    end

    // Contention: a CPU grant first so the round-robin flag points at CPU.
    drive(0, 1, 0, 1, 0, 1, 8'h30, 32'h0, 32'h0000AAAA);
    #1;
    chk("pre cpu write waitrequest", 32'(avs_waitrequest), 32'd0);
    @(negedge clk);
    drive(0, 1, 0, 1, 0, 1, 8'h20, 32'hC0C0C0C0, 32'h0000BBBB);
    #1;
    chk("cont1 ram_wdata", ram_wdata, 32'h0000AAAA);
    chk("cont1 ram_addr", 32'(ram_addr), 32'h07);
    chk("cont1 waitrequest", 32'(avs_waitrequest), 32'd1);
    @(negedge clk);
    drive(0, 0, 0, 1, 0, 1, 8'h20, 32'hC0C0C0C0, 32'h0);
    #1;
`ifdef OCIMEM_ARB_ROUND_ROBIN_EN
    chk("cont2 ram_wdata", ram_wdata, 32'hC0C0C0C0);
    chk("cont2 ram_addr", 32'(ram_addr), 32'h20);
    chk("cont2 waitrequest", 32'(avs_waitrequest), 32'd0);
    @(negedge clk);
    drive(0, 0, 0, 1, 0, 0, 8'h00, 32'h0, 32'h0);
    #1;
    chk("cont3 ram_wdata", ram_wdata, 32'h0000BBBB);
    chk("cont3 ram_addr", 32'(ram_addr), 32'h08);
    chk("cont3 ram_wr", 32'(ram_wr), 32'd1);
`else
    chk("cont2 ram_wdata", ram_wdata, 32'h0000BBBB);
    chk("cont2 ram_addr", 32'(ram_addr), 32'h08);
    chk("cont2 waitrequest", 32'(avs_waitrequest), 32'd1);
    @(negedge clk);
    #1;
    chk("cont3 ram_wdata", ram_wdata, 32'hC0C0C0C0);
    chk("cont3 ram_addr", 32'(ram_addr), 32'h20);
    chk("cont3 waitrequest", 32'(avs_waitrequest), 32'd0);
`endif
    @(negedge clk);

    // Reset while in CPU_RD with a JTAG write waiting in the slot.
    drive(0, 1, 0, 1, 1, 0, 8'h10, 32'h0, 32'h44);
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 0, 1, 1, 0, 8'h10, 32'h0, 32'h0);
    #1;
    chk("rst waitrequest during reset", 32'(avs_waitrequest), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 1, 0, 0, 8'h00, 32'h0, 32'h0);
    #1;
    chk("rst waitrequest after", 32'(avs_waitrequest), 32'd1);
    chk("rst slot cleared ram_wr", 32'(ram_wr), 32'd0);
    chk("rst ram_addr", 32'(ram_addr), 32'd0);
    chk("rst MonDReg", MonDReg, 32'd0);
    chk("rst monitor_ready", 32'(monitor_ready), 32'd0);
    @(negedge clk);
    drive(0, 0, 0, 1, 1, 0, 8'h10, 32'h0, 32'h0);
    #1;
    chk("post-rst grant waitrequest", 32'(avs_waitrequest), 32'd1);
    @(negedge clk);
    #1;
    chk("post-rst read waitrequest", 32'(avs_waitrequest), 32'd0);
    chk("post-rst readdata", avs_readdata, 32'h12345678);
    @(negedge clk);
    drive(0, 0, 0, 1, 0, 0, 8'h00, 32'h0, 32'h0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
